// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - shared types, AD9222 register constants and init table for the ADC SPI sequencer
package adc_spi_pkg;

    typedef enum logic [2:0] {
        S_BOOT,
        S_LOAD,
        S_CMD,
        S_REL,
        S_NEXT,
        S_IDLE
    } state_t;

    // Which word S_LOAD presents: table entry, host word, or the trailing transfer write
    typedef enum logic [1:0] {
        PH_INIT,
        PH_HOST,
        PH_XFER
    } phase_t;

    localparam logic [12:0] REG_TEST_IO  = 13'h00D;
    localparam logic [12:0] REG_OUT_MODE = 13'h014;
    localparam logic [12:0] REG_XFER     = 13'h0FF;
    localparam logic [7:0]  XFER_VAL     = 8'h01;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } spi_word_t;

    // Init table contents; also used as the reset value of the address/data outputs
    function automatic spi_word_t init_word(input logic [3:0] idx);
        case (idx)
            4'd0:    return '{addr: 13'h000,       data: 8'h18};
            4'd1:    return '{addr: REG_TEST_IO,   data: 8'h00};
            4'd2:    return '{addr: REG_OUT_MODE,  data: 8'h41};
            4'd3:    return '{addr: REG_XFER,      data: XFER_VAL};
            4'd4:    return '{addr: 13'h016,       data: 8'h00};
            4'd5:    return '{addr: 13'h018,       data: 8'h04};
            4'd6:    return '{addr: REG_TEST_IO,   data: 8'h00};
            4'd7:    return '{addr: REG_XFER,      data: XFER_VAL};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/adc_spi_init_rom.sv
// rtl/adc_spi_init_rom.sv - combinational init table lookup, zero past the configured length
module adc_spi_init_rom
    import adc_spi_pkg::*;
#(
    parameter int INIT_LEN = 8
) (
    input  logic [3:0] i_idx,
    output spi_word_t  o_word
);

    // Table lookup, blanking indices beyond INIT_LEN
    always_comb begin
        o_word = '0;
        if ({28'd0, i_idx} < INIT_LEN) begin
            o_word = init_word(i_idx);
        end
    end

endmodule

// File: rtl/adc_spi_sequencer.sv
// rtl/adc_spi_sequencer.sv - replays the AD9222 init table and serves host writes through the ADC SPI master
module adc_spi_sequencer
    import adc_spi_pkg::*;
#(
    parameter int INIT_LEN      = 8,
    parameter int AUTO_TRANSFER = 1,
    parameter int TIMEOUT_CYC   = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_start,
    output logic        init_done,
    input  logic        host_req,
    input  logic [12:0] host_addr,
    input  logic [7:0]  host_data,
    output logic        host_ack,
    output logic        busy,
    output logic        spi_err,
    output logic [12:0] spi_addr,
    output logic [7:0]  spi_data,
    output logic        spi_cmd,
    input  logic        spi_en,
    input  logic        spi_finish
);

    localparam logic [3:0]  LAST_IDX     = 4'(INIT_LEN - 1);
    localparam logic [14:0] TIMEOUT_LAST = 15'(TIMEOUT_CYC - 1);

    state_t      r_state, w_next;
    phase_t      r_phase, w_phase;
    logic [3:0]  r_idx, w_idx;
    logic [14:0] r_timer;
    logic        r_init_done, w_init_done;
    logic        r_err, w_err;
    logic        r_cmd;
    spi_word_t   r_word, w_word;
    spi_word_t   w_rom_word;
    logic        w_count;
    logic        w_timeout;
    logic        w_ack;

    adc_spi_init_rom #(
        .INIT_LEN(INIT_LEN)
    ) u_rom (
        .i_idx  (r_idx),
        .o_word (w_rom_word)
    );

    assign w_count   = (r_state == S_BOOT) || (r_state == S_CMD) || (r_state == S_REL);
    assign w_timeout = w_count && (r_timer == TIMEOUT_LAST);

    // Next-state, word selection and abort handling
    always_comb begin
        w_next      = r_state;
        w_phase     = r_phase;
        w_idx       = r_idx;
        w_init_done = r_init_done;
        w_err       = r_err;
        w_word      = r_word;
        w_ack       = 1'b0;
        case (r_state)
            S_BOOT: begin
                if (spi_en) begin
                    w_next  = S_LOAD;
                    w_idx   = 4'd0;
                    w_phase = PH_INIT;
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_LOAD: begin
                case (r_phase)
                    PH_INIT: w_word = w_rom_word;
                    PH_HOST: w_word = '{addr: host_addr, data: host_data};
                    default: w_word = '{addr: REG_XFER, data: XFER_VAL};
                endcase
                // Only raise the command once the master has reported idle
                if (spi_en) begin
                    w_next = S_CMD;
                end
            end
            S_CMD, S_REL: begin
                if ((r_state == S_CMD) ? spi_finish : spi_en) begin
                    w_next = (r_state == S_CMD) ? S_REL : S_NEXT;
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                    w_ack  = (r_phase != PH_INIT);
                end
            end
            S_NEXT: begin
                case (r_phase)
                    PH_INIT: begin
                        if (r_idx == LAST_IDX) begin
                            w_init_done = 1'b1;
                            w_next      = S_IDLE;
                        end else begin
                            w_idx  = r_idx + 4'd1;
                            w_next = S_LOAD;
                        end
                    end
                    PH_HOST: begin
                        if (AUTO_TRANSFER != 0) begin
                            w_phase = PH_XFER;
                            w_next  = S_LOAD;
                        end else begin
                            w_ack  = 1'b1;
                            w_next = S_IDLE;
                        end
                    end
                    default: begin
                        w_ack  = 1'b1;
                        w_next = S_IDLE;
                    end
                endcase
            end
            default: begin
                if (init_start) begin
                    w_init_done = 1'b0;
                    w_err       = 1'b0;
                    w_idx       = 4'd0;
                    w_phase     = PH_INIT;
                    w_next      = S_LOAD;
                end else if (host_req) begin
                    w_phase = PH_HOST;
                    w_next  = S_LOAD;
                end
            end
        endcase
    end

    // State, handshake outputs and the per-state wait timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_phase     <= PH_INIT;
            r_idx       <= 4'd0;
            r_timer     <= '0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
            r_cmd       <= 1'b0;
            r_word      <= init_word(4'd0);
        end else begin
            r_state     <= w_next;
            r_phase     <= w_phase;
            r_idx       <= w_idx;
            r_init_done <= w_init_done;
            r_err       <= w_err;
            r_word      <= w_word;
            r_cmd       <= (w_next == S_CMD);
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (w_count) begin
                r_timer <= r_timer + 15'd1;
            end
        end
    end

    assign init_done = r_init_done;
    assign spi_err   = r_err;
    assign spi_cmd   = r_cmd;
    assign spi_addr  = r_word.addr;
    assign spi_data  = r_word.data;
    assign busy      = (r_state != S_IDLE);
    assign host_ack  = w_ack;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb/tb_adc_spi_sequencer.sv - self-checking bench with a behavioural ADC_SPI master model
module tb_adc_spi_sequencer;

    localparam int INIT_LEN    = 3;
    localparam int TIMEOUT_CYC = 64;
    localparam int WR_CYC      = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_start = 1'b0;
    logic        host_req = 1'b0;
    logic [12:0] host_addr = '0;
    logic [7:0]  host_data = '0;
    logic        init_done, host_ack, busy, spi_err, spi_cmd;
    logic [12:0] spi_addr;
    logic [7:0]  spi_data;
    logic        spi_en, spi_finish;
    logic        stall = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [20:0] log_q[$];
    logic [20:0] exp_q[$];
    logic [20:0] ref_rom [0:7];

    int   ack_cnt = 0, viol_stable = 0, viol_rise = 0, cmd_run = 0, last_cmd_len = 0;
    logic p_cmd = 1'b0, p_en = 1'b0;
    logic [20:0] p_word = '0;

    int   m_st, m_cnt;
    logic m_boot, m_boot_log;

    adc_spi_sequencer #(
        .INIT_LEN(INIT_LEN),
        .AUTO_TRANSFER(1),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_done  (init_done),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .host_ack   (host_ack),
        .busy       (busy),
        .spi_err    (spi_err),
        .spi_addr   (spi_addr),
        .spi_data   (spi_data),
        .spi_cmd    (spi_cmd),
        .spi_en     (spi_en),
        .spi_finish (spi_finish)
    );

    always #5 clk = ~clk;

    // ADC_SPI master: one unsolicited write after reset, then one write per command rise
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st       <= 1;
            m_cnt      <= 0;
            m_boot     <= 1'b1;
            m_boot_log <= 1'b1;
            spi_en     <= 1'b0;
            spi_finish <= 1'b0;
        end else begin
            if (m_boot_log) begin
                log_q.push_back({spi_addr, spi_data});
                m_boot_log <= 1'b0;
            end
            case (m_st)
                1: begin
                    if (m_cnt == WR_CYC - 1) begin
                        if (m_boot) begin
                            m_st   <= 0;
                            m_boot <= 1'b0;
                            spi_en <= 1'b1;
                        end else if (!stall) begin
                            m_st       <= 2;
                            spi_finish <= 1'b1;
                        end
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                2: begin
                    if (!spi_cmd) begin
                        m_st       <= 0;
                        spi_finish <= 1'b0;
                        spi_en     <= 1'b1;
                    end
                end
                default: begin
                    if (spi_cmd) begin
                        log_q.push_back({spi_addr, spi_data});
                        m_st   <= 1;
                        m_cnt  <= 0;
                        spi_en <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Bus monitor: ack pulses, word stability under command, command rise rule, command length
    always @(negedge clk) begin
        if (!rst) begin
            if (host_ack) ack_cnt++;
            if (spi_cmd && p_cmd && ({spi_addr, spi_data} != p_word)) viol_stable++;
            if (spi_cmd && !p_cmd && !p_en) viol_rise++;
            if (spi_cmd) begin
                cmd_run++;
            end else if (cmd_run > 0) begin
                last_cmd_len = cmd_run;
                cmd_run = 0;
            end
        end
        p_cmd  = spi_cmd;
        p_en   = spi_en;
        p_word = {spi_addr, spi_data};
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input int mark);
        check($sformatf("%s_count", name), log_q.size() - mark, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (mark + i < log_q.size()) begin
                check($sformatf("%s_word%0d", name, i), 32'(log_q[mark + i]), 32'(exp_q[i]));
            end
        end
    endtask

    task automatic expect_init();
        for (int i = 0; i < INIT_LEN; i++) exp_q.push_back(ref_rom[i]);
    endtask

    task automatic expect_host(input logic [12:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        exp_q.push_back({13'h0FF, 8'h01});
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while ((busy || spi_en !== 1'b1) && n < max) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_idle_in_time", name), int'(n < max), 1);
    endtask

    // init_at: -1 none, 0 together with host_req, >0 that many cycles later
    task automatic host_write(input logic [12:0] a, input logic [7:0] d, input int init_at, input int max);
        int n;
        @(negedge clk);
        host_addr  = a;
        host_data  = d;
        host_req   = 1'b1;
        init_start = (init_at == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            init_start = (n == init_at);
        end while (!host_ack && n < max);
        init_start = 1'b0;
        host_req   = 1'b0;
        check("host_ack_seen", int'(n < max), 1);
    endtask

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        int          init_at;
        logic [20:0] exp_first;
        int          exp_len;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int mark, ack0, n;
        logic [12:0] ra;
        logic [7:0]  rd;
        logic        ri;

        ref_rom[0] = {13'h000, 8'h18};
        ref_rom[1] = {13'h00D, 8'h00};
        ref_rom[2] = {13'h014, 8'h41};
        ref_rom[3] = {13'h0FF, 8'h01};
        ref_rom[4] = {13'h016, 8'h00};
        ref_rom[5] = {13'h018, 8'h04};
        ref_rom[6] = {13'h00D, 8'h00};
        ref_rom[7] = {13'h0FF, 8'h01};

        vecs[0] = '{13'h00D, 8'h04, -1, {13'h00D, 8'h04}, 2};
        vecs[1] = '{13'h014, 8'h41,  0, {13'h000, 8'h18}, INIT_LEN + 2};
        vecs[2] = '{13'h1FF, 8'hA5, 10, {13'h1FF, 8'hA5}, 2};
        vecs[3] = '{13'h000, 8'h00, -1, {13'h000, 8'h00}, 2};

        // Reset values
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd", int'(spi_cmd), 0);
        check("rst_word", 32'({spi_addr, spi_data}), 32'({13'h000, 8'h18}));
        check("rst_init_done", int'(init_done), 0);
        check("rst_ack", int'(host_ack), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_err", int'(spi_err), 0);

        // Boot write plus the whole table after reset release
        mark = log_q.size();
        rst = 1'b0;
        wait_idle("boot", 1000);
        exp_q.delete();
        exp_q.push_back(ref_rom[0]);
        expect_init();
        check_log("boot", mark);
        check("boot_init_done", int'(init_done), 1);
        check("boot_busy", int'(busy), 0);

        // Table-driven host writes
        for (int v = 0; v < 4; v++) begin
            mark = log_q.size();
            ack0 = ack_cnt;
            host_write(vecs[v].addr, vecs[v].data, vecs[v].init_at, 1000);
            wait_idle($sformatf("vec%0d", v), 1000);
            exp_q.delete();
            if (vecs[v].init_at == 0) expect_init();
            expect_host(vecs[v].addr, vecs[v].data);
            check_log($sformatf("vec%0d", v), mark);
            check($sformatf("vec%0d_first", v), (log_q.size() > mark) ? 32'(log_q[mark]) : -1,
                  32'(vecs[v].exp_first));
            check($sformatf("vec%0d_len", v), log_q.size() - mark, vecs[v].exp_len);
            check($sformatf("vec%0d_acks", v), ack_cnt - ack0, 1);
            check($sformatf("vec%0d_init_done", v), int'(init_done), 1);
        end

        // Random host writes, occasionally with a simultaneous init_start
        for (int r = 0; r < 12; r++) begin
            ra = 13'($urandom);
            rd = 8'($urandom);
            ri = ($urandom_range(0, 3) == 0);
            mark = log_q.size();
            ack0 = ack_cnt;
            host_write(ra, rd, ri ? 0 : -1, 1000);
            wait_idle("rnd", 1000);
            exp_q.delete();
            if (ri) expect_init();
            expect_host(ra, rd);
            check_log($sformatf("rnd%0d", r), mark);
            check($sformatf("rnd%0d_acks", r), ack_cnt - ack0, 1);
        end

        // Stalled finish: timeout aborts the host write
        stall = 1'b1;
        mark = log_q.size();
        ack0 = ack_cnt;
        host_write(13'h014, 8'h55, -1, 400);
        repeat (2) @(negedge clk);
        check("to_err", int'(spi_err), 1);
        check("to_cmd", int'(spi_cmd), 0);
        check("to_busy", int'(busy), 0);
        check("to_cmd_len", last_cmd_len, TIMEOUT_CYC);
        check("to_acks", ack_cnt - ack0, 1);
        check("to_init_done", int'(init_done), 1);
        exp_q.delete();
        exp_q.push_back({13'h014, 8'h55});
        check_log("to", mark);
        stall = 1'b0;
        wait_idle("to_recover", 200);

        // init_start clears the error and replays the table
        mark = log_q.size();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        check("reinit_err_clr", int'(spi_err), 0);
        check("reinit_done_clr", int'(init_done), 0);
        wait_idle("reinit", 1000);
        exp_q.delete();
        expect_init();
        check_log("reinit", mark);
        check("reinit_done", int'(init_done), 1);

        // Reset during the second table write
        mark = log_q.size();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        n = 0;
        while (!(log_q.size() - mark >= 2 && spi_cmd) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", int'(n < 500), 1);
        rst = 1'b1;
        #1;
        check("mid_cmd_drop", int'(spi_cmd), 0);
        check("mid_busy", int'(busy), 1);
        check("mid_word", 32'({spi_addr, spi_data}), 32'({13'h000, 8'h18}));
        repeat (3) @(negedge clk);
        mark = log_q.size();
        rst = 1'b0;
        wait_idle("mid", 1000);
        exp_q.delete();
        exp_q.push_back(ref_rom[0]);
        expect_init();
        check_log("mid", mark);
        check("mid_init_done", int'(init_done), 1);

        check("word_stable_under_cmd", viol_stable, 0);
        check("cmd_rise_needs_en", viol_rise, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
